// File: rtl/ex_iter_alu_if.sv
// ex_iter_alu_if: the id/ex -> ex -> ex/mem bundle for the execute stage.
//   master : id/ex side. It drives the op (valid_i, op_i, reg1_i, reg2_i, wd_i,
//            wreg_i, flush_i) and receives the results and handshake.
//   slave  : execute stage. It receives the op and drives ready_o, valid_o,
//            wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o and stallreq_o.
interface ex_iter_alu_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          valid_i;
    logic          ready_o;
    logic [3:0]    op_i;
    logic [DW-1:0] reg1_i;
    logic [DW-1:0] reg2_i;
    logic [AW-1:0] wd_i;
    logic          wreg_i;
    logic          flush_i;
    logic          valid_o;
    logic [AW-1:0] wd_o;
    logic          wreg_o;
    logic [DW-1:0] wdata_o;
    logic          whilo_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic          stallreq_o;

    modport master (
        output valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  ready_o, valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
    modport slave (
        input  valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output ready_o, valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_iter_alu.sv
// ex_iter_alu: execute stage with single-cycle logic, shift, add/sub and
// compare ops, plus an iterative restoring divider (DIV/DIVU) writing HI/LO.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ex_iter_alu_if.slave. It carries the op and handshake in, and the
//              registered results, ready_o and stallreq_o out.
// Results are registered. valid_o is a single-cycle pulse for each accepted op.
// A divide keeps ready_o low for its DW iterations and for the DONE cycle.
module ex_iter_alu #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int SHW = 5
) (
    input  logic        clk,
    input  logic        rst,
    ex_iter_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t         state, state_nx;
    logic           accept, is_div, is_sdiv, legal;
    logic [SHW-1:0] shamt, cnt;
    logic [DW-1:0]  alu_res, a_abs, b_abs;
    logic [DW-1:0]  quot, rem, dvs, quot_n, rem_n;
    logic [DW:0]    rem_sh, diff;
    logic           qneg, rneg, dz;
    logic [AW-1:0]  wd_q;

    assign is_div  = (bus.op_i == 4'd11) || (bus.op_i == 4'd12);
    assign is_sdiv = (bus.op_i == 4'd11);
    assign legal   = (bus.op_i <= 4'd10);
    assign shamt   = bus.reg1_i[SHW-1:0];
    assign accept  = bus.valid_i & bus.ready_o & ~bus.flush_i;

    // Single-cycle result. Illegal ops fall to the default and produce 0.
    always_comb begin
        alu_res = '0;
        case (bus.op_i)
            4'd0:    alu_res = bus.reg1_i | bus.reg2_i;
            4'd1:    alu_res = bus.reg1_i & bus.reg2_i;
            4'd2:    alu_res = ~(bus.reg1_i | bus.reg2_i);
            4'd3:    alu_res = bus.reg1_i ^ bus.reg2_i;
            4'd4:    alu_res = bus.reg2_i << shamt;
            4'd5:    alu_res = bus.reg2_i >> shamt;
            4'd6:    alu_res = $signed(bus.reg2_i) >>> shamt;
            4'd7:    alu_res = bus.reg1_i + bus.reg2_i;
            4'd8:    alu_res = bus.reg1_i - bus.reg2_i;
            4'd9:    alu_res = {{(DW-1){1'b0}}, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
            4'd10:   alu_res = {{(DW-1){1'b0}}, bus.reg1_i < bus.reg2_i};
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes. DIVU takes the operands unchanged.
    assign a_abs = (is_sdiv && bus.reg1_i[DW-1]) ? -bus.reg1_i : bus.reg1_i;
    assign b_abs = (is_sdiv && bus.reg2_i[DW-1]) ? -bus.reg2_i : bus.reg2_i;

    // One restoring step. quot first holds the dividend: its MSB shifts into the
    // partial remainder and the new quotient bit enters at the LSB. rem is always
    // below dvs, so a borrow appears only in diff[DW].
    assign rem_sh = {rem, quot[DW-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign rem_n  = diff[DW] ? rem_sh[DW-1:0] : diff[DW-1:0];
    assign quot_n = {quot[DW-2:0], ~diff[DW]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.ready_o    = (state == IDLE);
        bus.stallreq_o = (state == DIV);
        case (state)
            IDLE:    if (accept && is_div) state_nx = DIV;
            DIV:     if (cnt == SHW'(DW-1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush_i) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_o <= 1'b0;
            bus.whilo_o <= 1'b0;
            bus.wreg_o  <= 1'b0;
            bus.wd_o    <= '0;
            bus.wdata_o <= '0;
            bus.hi_o    <= '0;
            bus.lo_o    <= '0;
            quot <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
            dz   <= 1'b0;
            wd_q <= '0;
        end else begin
            bus.valid_o <= 1'b0;
            bus.whilo_o <= 1'b0;
            bus.wreg_o  <= 1'b0;
            if (!bus.flush_i) begin
                if (accept && !is_div) begin
                    bus.valid_o <= 1'b1;
                    bus.wd_o    <= bus.wd_i;
                    bus.wreg_o  <= bus.wreg_i & legal;
                    bus.wdata_o <= alu_res;
                end
                if (accept && is_div) begin
                    quot <= a_abs;
                    rem  <= '0;
                    dvs  <= b_abs;
                    cnt  <= '0;
                    dz   <= (bus.reg2_i == '0);
                    // The zero-divisor quotient is forced to all ones, so no sign
                    // fix applies to it.
                    qneg <= is_sdiv & (bus.reg1_i[DW-1] ^ bus.reg2_i[DW-1]) & (bus.reg2_i != '0);
                    rneg <= is_sdiv & bus.reg1_i[DW-1];
                    wd_q <= bus.wd_i;
                end
                if (state == DIV) begin
                    quot <= quot_n;
                    rem  <= rem_n;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == SHW'(DW-1)) begin
                        bus.valid_o <= 1'b1;
                        bus.whilo_o <= 1'b1;
                        bus.wd_o    <= wd_q;
                        bus.wdata_o <= '0;
                        // For MIN/-1 the magnitude quotient is 2^(DW-1), and its
                        // negation wraps back to MIN.
                        bus.lo_o    <= dz ? '1 : (qneg ? -quot_n : quot_n);
                        // The remainder takes the dividend's sign. For a zero
                        // divisor this reproduces the dividend.
                        bus.hi_o    <= rneg ? -rem_n : rem_n;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_iter_alu.sv
module tb_ex_iter_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_iter_alu_if #(.DW(32), .AW(5)) bif ();
    ex_iter_alu #(.DW(32), .AW(5), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        ewreg;
    } sv_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, lo, hi;
    } dv_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks   = 0;
    int failures = 0;
    logic [31:0] last_hi = '0, last_lo = '0;
    sv_t sv[17];
    dv_t dv[8];

    // Scoreboard: every valid_o must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bif.valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid wdata=%h wd=%0d whilo=%b", bif.wdata_o, bif.wd_o, bif.whilo_o);
            end else begin
                mon_e = sb.pop_front();
                if (bif.wdata_o !== mon_e.wdata || bif.wd_o !== mon_e.wd || bif.wreg_o !== mon_e.wreg ||
                    bif.whilo_o !== mon_e.whilo || bif.hi_o !== mon_e.hi || bif.lo_o !== mon_e.lo) begin
                    failures++;
                    $display("FAIL result got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h exp wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h",
                             bif.wdata_o, bif.wd_o, bif.wreg_o, bif.whilo_o, bif.hi_o, bif.lo_o,
                             mon_e.wdata, mon_e.wd, mon_e.wreg, mon_e.whilo, mon_e.hi, mon_e.lo);
                end
            end
        end
    end

    // Called #1 after a rising edge. Waits for ready_o, then holds the op for one edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wreg);
        int n = 0;
        while (!bif.ready_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bif.ready_o) begin
            checks++; failures++;
            $display("FAIL ready_timeout ready_o=%b required=1", bif.ready_o);
        end
        bif.valid_i = 1'b1; bif.op_i = op; bif.reg1_i = r1; bif.reg2_i = r2;
        bif.wd_i = wd; bif.wreg_i = wreg;
        @(posedge clk); #1;
        bif.valid_i = 1'b0;
    endtask

    task automatic push_single(input sv_t v);
        exp_t e;
        e.wdata = v.wdata; e.wd = v.wd; e.wreg = v.ewreg; e.whilo = 1'b0;
        e.hi = last_hi; e.lo = last_lo;
        sb.push_back(e);
    endtask

    task automatic push_div(input logic [4:0] wd, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.wdata = '0; e.wd = wd; e.wreg = 1'b0; e.whilo = 1'b1; e.hi = hi; e.lo = lo;
        last_hi = hi; last_lo = lo;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int stall_cnt;
        sv[0]  = '{4'd0,  32'hF0F0_0000, 32'h0F0F_1234, 5'd3,  1'b1, 32'hFFFF_1234, 1'b1};
        sv[1]  = '{4'd6,  32'h0000_0004, 32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001, 1'b1};
        sv[2]  = '{4'd4,  32'h0000_0004, 32'h8000_0010, 5'd5,  1'b1, 32'h0000_0100, 1'b1};
        sv[3]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 5'd6,  1'b1, 32'h0000_0001, 1'b1};
        sv[4]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  1'b1, 32'h0000_0000, 1'b1};
        sv[5]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd8,  1'b1, 32'h0000_0000, 1'b1};
        sv[6]  = '{4'd8,  32'h0000_0000, 32'h0000_0001, 5'd9,  1'b1, 32'hFFFF_FFFF, 1'b1};
        sv[7]  = '{4'd5,  32'h0000_0004, 32'h8000_0010, 5'd10, 1'b1, 32'h0800_0001, 1'b1};
        sv[8]  = '{4'd2,  32'h0000_0000, 32'h0000_0000, 5'd11, 1'b1, 32'hFFFF_FFFF, 1'b1};
        sv[9]  = '{4'd1,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd12, 1'b1, 32'h0F00_0F00, 1'b1};
        sv[10] = '{4'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd13, 1'b1, 32'hF0F0_F0F0, 1'b1};
        sv[11] = '{4'd4,  32'h0000_003F, 32'h0000_0003, 5'd14, 1'b1, 32'h8000_0000, 1'b1};
        sv[12] = '{4'd13, 32'h1234_5678, 32'h0000_0001, 5'd15, 1'b1, 32'h0000_0000, 1'b0};
        sv[13] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'h0000_0000, 1'b0};
        sv[14] = '{4'd7,  32'h0000_0005, 32'h0000_0007, 5'd31, 1'b0, 32'h0000_000C, 1'b0};
        sv[15] = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 5'd17, 1'b1, 32'h0000_0000, 1'b1};
        sv[16] = '{4'd10, 32'h0000_0001, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'h0000_0001, 1'b1};

        dv[0] = '{4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        dv[1] = '{4'd12, 32'd10,        32'h0000_0000, 32'hFFFF_FFFF, 32'd10};
        dv[2] = '{4'd11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        dv[3] = '{4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        dv[4] = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 32'h0000_0000};
        dv[5] = '{4'd11, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        dv[6] = '{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        dv[7] = '{4'd11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};

        bif.valid_i = 1'b0; bif.op_i = '0; bif.reg1_i = '0; bif.reg2_i = '0;
        bif.wd_i = '0; bif.wreg_i = 1'b0; bif.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        checks++;
        if (bif.valid_o !== 1'b0 || bif.ready_o !== 1'b1 || bif.stallreq_o !== 1'b0 || bif.wreg_o !== 1'b0 ||
            bif.whilo_o !== 1'b0 || bif.wdata_o !== '0 || bif.hi_o !== '0 || bif.lo_o !== '0 || bif.wd_o !== '0) begin
            failures++;
            $display("FAIL reset_state valid=%b ready=%b stall=%b wdata=%h hi=%h lo=%h required 0/1/0/0/0/0",
                     bif.valid_o, bif.ready_o, bif.stallreq_o, bif.wdata_o, bif.hi_o, bif.lo_o);
        end
        @(posedge clk); #1;

        // Single-cycle ops, issued back to back
        for (int i = 0; i < 17; i++) begin
            push_single(sv[i]);
            issue(sv[i].op, sv[i].r1, sv[i].r2, sv[i].wd, sv[i].wreg);
        end
        drain();

        // Divide latency: stall for DW cycles, result in the following cycle
        push_div(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 5'd20, 1'b1);
        stall_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bif.stallreq_o && !bif.ready_o && !bif.valid_o) stall_cnt++;
        end
        checks++;
        if (stall_cnt != 32) begin
            failures++;
            $display("FAIL div_stall_cycles got=%0d required=32", stall_cnt);
        end
        @(negedge clk);
        checks++;
        if (bif.valid_o !== 1'b1 || bif.stallreq_o !== 1'b0 || bif.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL div_done_cycle valid=%b stall=%b ready=%b required 1/0/0", bif.valid_o, bif.stallreq_o, bif.ready_o);
        end
        drain();

        // Divide table
        for (int i = 0; i < 8; i++) begin
            push_div(5'(i + 1), dv[i].hi, dv[i].lo);
            issue(dv[i].op, dv[i].a, dv[i].b, 5'(i + 1), 1'b1);
        end
        drain();
        // HI/LO holds through a following single-cycle op
        push_single(sv[5]);
        issue(sv[5].op, sv[5].r1, sv[5].r2, sv[5].wd, sv[5].wreg);
        drain();

        // A flush at iteration 10 aborts the divide
        issue(4'd12, 32'd100, 32'd7, 5'd2, 1'b1);
        repeat (9) @(posedge clk);
        #1 bif.flush_i = 1'b1;
        @(posedge clk); #1 bif.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.ready_o !== 1'b1 || bif.stallreq_o !== 1'b0 || bif.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_abort ready=%b stall=%b valid=%b required 1/0/0", bif.ready_o, bif.stallreq_o, bif.valid_o);
        end
        // A flush in the same cycle as valid_i blocks the accept
        @(posedge clk); #1;
        bif.valid_i = 1'b1; bif.op_i = 4'd7; bif.flush_i = 1'b1;
        @(posedge clk); #1;
        bif.valid_i = 1'b0; bif.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_accept valid=%b required=0", bif.valid_o);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bif.hi_o !== last_hi || bif.lo_o !== last_lo) begin
            failures++;
            $display("FAIL flush_hilo_hold hi=%h lo=%h required hi=%h lo=%h", bif.hi_o, bif.lo_o, last_hi, last_lo);
        end

        // Reset during iteration 5 of a divide
        issue(4'd11, 32'h1234_5678, 32'h0000_0003, 5'd9, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        last_hi = '0; last_lo = '0;
        @(negedge clk);
        checks++;
        if (bif.valid_o !== 1'b0 || bif.ready_o !== 1'b1 || bif.stallreq_o !== 1'b0 || bif.wreg_o !== 1'b0 ||
            bif.whilo_o !== 1'b0 || bif.wdata_o !== '0 || bif.hi_o !== '0 || bif.lo_o !== '0 || bif.wd_o !== '0) begin
            failures++;
            $display("FAIL mid_div_reset valid=%b ready=%b stall=%b wdata=%h hi=%h lo=%h required 0/1/0/0/0/0",
                     bif.valid_o, bif.ready_o, bif.stallreq_o, bif.wdata_o, bif.hi_o, bif.lo_o);
        end
        @(posedge clk); #1;
        push_single(sv[5]);
        issue(sv[5].op, sv[5].r1, sv[5].r2, sv[5].wd, sv[5].wreg);
        drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached required=finish");
        $fatal(1, "timeout");
    end
endmodule
